// File: rtl/uart_rx.sv
// uart_rx: UART receiver, counterpart of uart_tx.
// Frame: start(0), DATA_WIDTH data bits LSB first, optional parity, one stop(1).
// The asynchronous line goes through a 2-flop synchronizer. Each bit is sampled
// at its mid-point by a down-counting baud counter.
// Received words are handed to the consumer on a valid/ready handshake.
//
// Handshake: o_vld high means o_data/o_parity_err hold a word. A word is
// transferred on every rising clk edge where o_vld && i_rdy. o_data and
// o_parity_err stay stable while o_vld is high and the word has not been
// transferred. i_rdy has no effect while o_vld is low.
//
// dbg_state exposes the receive FSM (encoding: see the localparams below).
module uart_rx #(
  parameter int    DATA_WIDTH   = 8,
  parameter string PARITY_CHECK = "NONE",
  parameter int    CLK_FREQ     = 50000000,
  parameter int    RX_FREQ      = 9600
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  o_vld,
  input  logic                  i_rdy,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_overrun,
  output logic [2:0]            dbg_state
);

  localparam int DIV   = CLK_FREQ / RX_FREQ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam bit PAR_ODD  = (PARITY_CHECK == "ODD");
  localparam bit PAR_EVEN = (PARITY_CHECK == "EVEN");
  localparam bit PAR_EN   = PAR_ODD || PAR_EVEN;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  // Elaboration-time parameter checks.
  if (DATA_WIDTH < 1) begin : g_dw_fatal
    $fatal(1, "uart_rx: DATA_WIDTH must be >= 1");
  end
  if (DATA_WIDTH > 8) begin : g_dw_warn
    $warning("uart_rx: DATA_WIDTH > 8 is outside the uart_tx range");
  end
  if (!(PARITY_CHECK == "NONE" || PAR_ODD || PAR_EVEN)) begin : g_par_fatal
    $fatal(1, "uart_rx: PARITY_CHECK must be NONE, ODD or EVEN");
  end
  if (DIV < 16) begin : g_div_fatal
    $fatal(1, "uart_rx: CLK_FREQ/RX_FREQ must be >= 16");
  end

  logic                  rx_q1;
  logic                  rx_s;
  logic                  rx_s_d;
  logic [2:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_err;
  logic                  tick;
  logic                  stop_ok;
  logic                  stop_bad;

  assign dbg_state = state;
  assign tick      = (cnt == '0);
  assign stop_ok   = (state == S_STOP) && tick && rx_s;
  assign stop_bad  = (state == S_STOP) && tick && !rx_s;

  // Two-flop synchronizer plus one more stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q1  <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_q1  <= rx;
      rx_s   <= rx_q1;
      rx_s_d <= rx_s;
    end
  end

  // Receive FSM: finds the start edge, samples each bit at mid-point.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift_reg <= '0;
      par_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_s_d && !rx_s) begin
            state <= S_START;
            cnt   <= CNT_HALF;
          end
        end
        S_START: begin
          if (tick) begin
            if (!rx_s) begin
              state <= S_DATA;
              cnt   <= CNT_FULL;
              idx   <= '0;
            end else begin
              // Start bit not low at mid-point: treat as a glitch.
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (tick) begin
            shift_reg[idx] <= rx_s;
            cnt            <= CNT_FULL;
            if (idx == IDX_LAST) begin
              state <= PAR_EN ? S_PARITY : S_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_PARITY: begin
          if (tick) begin
            // Even parity: total ones count (data + parity bit) must be even.
            par_err <= PAR_EN && ((^{shift_reg, rx_s}) ^ PAR_ODD);
            cnt     <= CNT_FULL;
            state   <= S_STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (tick) begin
            // Leaving at the stop-bit mid-point lets the next start edge be seen early.
            state <= rx_s ? S_IDLE : S_BREAK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output holding register, handshake and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_vld        <= 1'b0;
      o_data       <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_frame_err <= stop_bad;
      o_overrun   <= 1'b0;
      if (stop_ok) begin
        if (!o_vld || i_rdy) begin
          o_vld        <= 1'b1;
          o_data       <= shift_reg;
          o_parity_err <= par_err;
        end else begin
          // Consumer still holds the previous word: drop the new one.
          o_overrun <= 1'b1;
        end
      end else if (o_vld && i_rdy) begin
        o_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: bench for uart_rx with DIV=16 (CLK_FREQ=160000, RX_FREQ=10000).
// Three receivers share clk/rst: index 0 has no parity, 1 EVEN, 2 ODD.
// Each has its own rx line and i_rdy.
module tb_uart_rx;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BREAK = 3'd5;
  localparam int         BIT_CLKS = 16;

  logic       clk;
  logic       rst;
  logic [2:0] rx_l;
  logic [2:0] rdy;
  logic [2:0] vld;
  logic [2:0] perr;
  logic [2:0] ferr;
  logic [2:0] ovr;
  logic [7:0] dat [3];
  logic [2:0] st  [3];

  logic [10:0] exp_q[$];
  int n_vec;
  int n_err;
  int ferr_cnt [3];
  int ovr_cnt  [3];

  uart_rx #(.DATA_WIDTH(8), .PARITY_CHECK("NONE"), .CLK_FREQ(160000), .RX_FREQ(10000)) u_none (
    .clk(clk), .rst(rst), .rx(rx_l[0]), .o_vld(vld[0]), .i_rdy(rdy[0]), .o_data(dat[0]),
    .o_parity_err(perr[0]), .o_frame_err(ferr[0]), .o_overrun(ovr[0]), .dbg_state(st[0])
  );

  uart_rx #(.DATA_WIDTH(8), .PARITY_CHECK("EVEN"), .CLK_FREQ(160000), .RX_FREQ(10000)) u_even (
    .clk(clk), .rst(rst), .rx(rx_l[1]), .o_vld(vld[1]), .i_rdy(rdy[1]), .o_data(dat[1]),
    .o_parity_err(perr[1]), .o_frame_err(ferr[1]), .o_overrun(ovr[1]), .dbg_state(st[1])
  );

  uart_rx #(.DATA_WIDTH(8), .PARITY_CHECK("ODD"), .CLK_FREQ(160000), .RX_FREQ(10000)) u_odd (
    .clk(clk), .rst(rst), .rx(rx_l[2]), .o_vld(vld[2]), .i_rdy(rdy[2]), .o_data(dat[2]),
    .o_parity_err(perr[2]), .o_frame_err(ferr[2]), .o_overrun(ovr[2]), .dbg_state(st[2])
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: on the falling edge, pop and compare every word handed over,
  // and count error pulses per receiver.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst && vld[i] && rdy[i]) begin
        logic [10:0] got;
        logic [10:0] want;
        got   = {2'(i), perr[i], dat[i]};
        n_vec = n_vec + 1;
        if (exp_q.size() == 0) begin
          n_err = n_err + 1;
          $display("FAIL word_rx%0d: got data=%02h perr=%0b, expected no word", i, dat[i], perr[i]);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_err = n_err + 1;
            $display("FAIL word_rx%0d: got rx%0d data=%02h perr=%0b, expected rx%0d data=%02h perr=%0b",
                     i, got[10:9], got[7:0], got[8], want[10:9], want[7:0], want[8]);
          end
        end
      end
      if (!rst && ferr[i]) ferr_cnt[i] = ferr_cnt[i] + 1;
      if (!rst && ovr[i])  ovr_cnt[i]  = ovr_cnt[i] + 1;
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input int inst, input logic b);
    rx_l[inst] = b;
    tick(BIT_CLKS);
  endtask

  task automatic send_frame(input int inst, input logic [7:0] d, input bit has_par,
                            input logic p, input logic stop);
    drive_bit(inst, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(inst, d[i]);
    if (has_par) drive_bit(inst, p);
    drive_bit(inst, stop);
    rx_l[inst] = 1'b1;
  endtask

  task automatic expect_word(input int inst, input logic [7:0] d, input logic pe);
    exp_q.push_back({2'(inst), pe, d});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) tick(1);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Directed stimulus.
  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 3; i++) begin
      ferr_cnt[i] = 0;
      ovr_cnt[i]  = 0;
    end
    rst  = 1'b1;
    rx_l = 3'b111;
    rdy  = 3'b111;
    tick(4);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_vld%0d", i),  32'(vld[i]),  32'd0);
      check($sformatf("rst_data%0d", i), 32'(dat[i]),  32'd0);
      check($sformatf("rst_perr%0d", i), 32'(perr[i]), 32'd0);
      check($sformatf("rst_ferr%0d", i), 32'(ferr[i]), 32'd0);
      check($sformatf("rst_ovr%0d", i),  32'(ovr[i]),  32'd0);
      check($sformatf("rst_state%0d", i), 32'(st[i]),  32'(ST_IDLE));
    end
    rst = 1'b0;
    tick(20);

    // Single frame, then two frames back-to-back, no parity.
    expect_word(0, 8'hA5, 1'b0);
    send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
    tick(BIT_CLKS);
    wait_drain("drain_a5");
    expect_word(0, 8'hA5, 1'b0);
    expect_word(0, 8'h3C, 1'b0);
    send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
    send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
    tick(BIT_CLKS);
    wait_drain("drain_b2b");

    // EVEN parity: 0x07 has three ones, so parity bit 1 is correct.
    expect_word(1, 8'h07, 1'b0);
    send_frame(1, 8'h07, 1, 1'b1, 1'b1);
    expect_word(1, 8'h07, 1'b1);
    send_frame(1, 8'h07, 1, 1'b0, 1'b1);
    tick(BIT_CLKS);
    wait_drain("drain_even");

    // ODD parity: parity bit 0 is correct for 0x07.
    expect_word(2, 8'h07, 1'b0);
    send_frame(2, 8'h07, 1, 1'b0, 1'b1);
    expect_word(2, 8'h07, 1'b1);
    send_frame(2, 8'h07, 1, 1'b1, 1'b1);
    tick(BIT_CLKS);
    wait_drain("drain_odd");

    // Short low glitch on an idle line is rejected silently.
    rx_l[0] = 1'b0;
    tick(4);
    rx_l[0] = 1'b1;
    tick(40);
    check("glitch_state", 32'(st[0]), 32'(ST_IDLE));
    check("glitch_ferr", 32'(ferr_cnt[0]), 32'd0);
    check("glitch_vld", 32'(vld[0]), 32'd0);
    expect_word(0, 8'h55, 1'b0);
    send_frame(0, 8'h55, 0, 1'b0, 1'b1);
    tick(BIT_CLKS);
    wait_drain("drain_55");

    // Stop bit low, then a line break: one framing error, no word.
    send_frame(0, 8'h5A, 0, 1'b0, 1'b0);
    rx_l[0] = 1'b0;
    tick(40);
    check("break_state", 32'(st[0]), 32'(ST_BREAK));
    check("break_vld", 32'(vld[0]), 32'd0);
    rx_l[0] = 1'b1;
    tick(BIT_CLKS);
    check("break_ferr", 32'(ferr_cnt[0]), 32'd1);
    check("break_data", 32'(dat[0]), 32'h55);
    expect_word(0, 8'h81, 1'b0);
    send_frame(0, 8'h81, 0, 1'b0, 1'b1);
    tick(BIT_CLKS);
    wait_drain("drain_81");
    check("break_ferr_after", 32'(ferr_cnt[0]), 32'd1);

    // Consumer stalled: second word is dropped with an overrun pulse.
    rdy[0] = 1'b0;
    expect_word(0, 8'h11, 1'b0);
    send_frame(0, 8'h11, 0, 1'b0, 1'b1);
    send_frame(0, 8'h22, 0, 1'b0, 1'b1);
    tick(BIT_CLKS);
    check("ovr_vld", 32'(vld[0]), 32'd1);
    check("ovr_data", 32'(dat[0]), 32'h11);
    check("ovr_count", 32'(ovr_cnt[0]), 32'd1);
    rdy[0] = 1'b1;
    tick(2);
    check("ovr_vld_cleared", 32'(vld[0]), 32'd0);
    wait_drain("drain_ovr");

    // Reset mid data bit 3 with a stale word held: everything clears.
    rdy[0] = 1'b0;
    send_frame(0, 8'h99, 0, 1'b0, 1'b1);
    tick(BIT_CLKS);
    check("stale_vld", 32'(vld[0]), 32'd1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    rx_l[0] = 1'b1;
    tick(8);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_vld", 32'(vld[0]), 32'd0);
    check("mid_rst_data", 32'(dat[0]), 32'd0);
    check("mid_rst_perr", 32'(perr[0]), 32'd0);
    check("mid_rst_state", 32'(st[0]), 32'(ST_IDLE));
    rdy[0] = 1'b1;
    tick(2 * BIT_CLKS);
    check("mid_rst_no_word", 32'(vld[0]), 32'd0);
    expect_word(0, 8'hC3, 1'b0);
    send_frame(0, 8'hC3, 0, 1'b0, 1'b1);
    tick(BIT_CLKS);
    wait_drain("drain_c3");
    check("final_ferr", 32'(ferr_cnt[0]), 32'd1);
    check("final_ovr", 32'(ovr_cnt[0]), 32'd1);
    check("final_ferr_par", 32'(ferr_cnt[1] + ferr_cnt[2]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
